// File: rtl/mac_tree_engine.sv
// mac_tree_engine: streaming dot-product engine. Each accepted beat supplies LANES operand pairs.
// The pairs are multiplied in parallel, reduced by a registered adder tree and added into a
// wrapping accumulator that has a sticky overflow flag.
//
// Ports:
//   clock, reset_l          sole clock (rising edge); asynchronous active-low reset
//   start, length,          job request (sampled in IDLE); beat count and operand signedness,
//   signed_mode             both latched when the job starts
//   in_valid, in_ready      beat handshake; in_ready is high only in RUN
//   a_data, b_data          lane i operand at [i*DATA_W +: DATA_W]
//   result, result_valid,   accumulated dot product; it is final while result_valid is high
//   result_ready            consumer accept; DONE returns to IDLE on this signal
//   overflow                sticky accumulator overflow for the current job
//   cycle_count             cycles spent in RUN and DRAIN, saturating
module mac_tree_engine #(
   parameter int unsigned LANES  = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(LANES) + 8,
   parameter int unsigned LEN_W  = 12,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                    clock,
   input  logic                    reset_l,
   input  logic                    start,
   input  logic [LEN_W-1:0]        length,
   input  logic                    signed_mode,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] a_data,
   input  logic [LANES*DATA_W-1:0] b_data,
   output logic [ACC_W-1:0]        result,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic                    overflow,
   output logic [CNT_W-1:0]        cycle_count
);

   localparam int unsigned PW    = 2 * DATA_W;
   localparam int unsigned LOG_L = $clog2(LANES);
   localparam int unsigned TW    = PW + LOG_L;
   // Adder width that covers both the accumulator and the tree sum plus one guard bit.
   // With this width, overflow detection also works when ACC_W < TW.
   localparam int unsigned XW    = ((ACC_W > TW) ? ACC_W : TW) + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q;
   logic             signed_q;
   logic [LEN_W-1:0] beat_q;
   logic             drain_q;
   logic [PW-1:0]    prod_q [LANES];
   logic [PW-1:0]    prod_d [LANES];
   logic             p_valid_q;
   logic [TW-1:0]    tree_sum;
   logic [TW-1:0]    sum_q;
   logic             s_valid_q;
   logic [ACC_W-1:0] acc_q;
   logic             ovf_q;
   logic [CNT_W-1:0] cnt_q;

   logic             job_start;
   logic             accept;
   logic             last_beat;
   logic [XW-1:0]    acc_x;
   logic [XW-1:0]    sum_x;
   logic [XW-1:0]    acc_full;
   logic [XW-ACC_W:0] acc_top;
   logic             acc_ovf;

   assign job_start = (state_q == StIdle) && start;
   assign accept    = (state_q == StRun) && in_valid;
   assign last_beat = accept && (beat_q == (len_q - LEN_W'(1)));

   // Lane multipliers. The operands are extended to full product width, so the low PW bits of
   // the product are correct for both signed and unsigned operands.
   always_comb begin
      logic [PW-1:0] a_x;
      logic [PW-1:0] b_x;
      a_x = '0;
      b_x = '0;
      for (int i = 0; i < LANES; i++) begin
         a_x = {{DATA_W{signed_q & a_data[i*DATA_W+DATA_W-1]}}, a_data[i*DATA_W +: DATA_W]};
         b_x = {{DATA_W{signed_q & b_data[i*DATA_W+DATA_W-1]}}, b_data[i*DATA_W +: DATA_W]};
         prod_d[i] = a_x * b_x;
      end
   end

   // Adder tree: level 0 holds the extended products, and each later level halves the node count.
   for (genvar l = 0; l <= LOG_L; l++) begin : g_lvl
      localparam int unsigned N = LANES >> l;
      logic [N*TW-1:0] node;
      if (l == 0) begin : g_leaf
         for (genvar i = 0; i < N; i++) begin : g_ext
            assign node[i*TW +: TW] = {{LOG_L{signed_q & prod_q[i][PW-1]}}, prod_q[i]};
         end
      end else begin : g_add
         for (genvar i = 0; i < N; i++) begin : g_sum
            assign node[i*TW +: TW] = g_lvl[l-1].node[(2*i)*TW +: TW]
                                    + g_lvl[l-1].node[(2*i+1)*TW +: TW];
         end
      end
   end
   assign tree_sum = g_lvl[LOG_L].node[TW-1:0];

   // Accumulate at the wider width. The job overflows if the bits above the accumulator are not
   // a pure zero-extension (unsigned) or sign-extension (signed) of the wrapped result.
   always_comb begin
      acc_x    = {{(XW-ACC_W){signed_q & acc_q[ACC_W-1]}}, acc_q};
      sum_x    = {{(XW-TW){signed_q & sum_q[TW-1]}}, sum_q};
      acc_full = acc_x + sum_x;
      acc_top  = acc_full[XW-1:ACC_W-1];
      if (signed_q) begin
         acc_ovf = !((&acc_top) || !(|acc_top));
      end else begin
         acc_ovf = |acc_full[XW-1:ACC_W];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = (length != '0) ? StRun : StDone;
         StRun:   if (last_beat) state_d = StDrain;
         // The final beat reaches the accumulator on DRAIN's second edge.
         StDrain: if (drain_q) state_d = StDone;
         StDone:  if (result_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         state_q   <= StIdle;
         len_q     <= '0;
         signed_q  <= 1'b0;
         beat_q    <= '0;
         drain_q   <= 1'b0;
         for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
         p_valid_q <= 1'b0;
         sum_q     <= '0;
         s_valid_q <= 1'b0;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         if (job_start) begin
            len_q    <= length;
            signed_q <= signed_mode;
            beat_q   <= '0;
         end else if (accept) begin
            beat_q <= beat_q + LEN_W'(1);
         end
         drain_q   <= (state_q == StDrain) && !drain_q;
         p_valid_q <= accept;
         if (accept) begin
            for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
         end
         s_valid_q <= p_valid_q;
         if (p_valid_q) sum_q <= tree_sum;
         if (job_start) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
         end else begin
            if (s_valid_q) begin
               acc_q <= acc_full[ACC_W-1:0];
               if (acc_ovf) ovf_q <= 1'b1;
            end
            if (((state_q == StRun) || (state_q == StDrain)) && (cnt_q != '1)) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign in_ready     = (state_q == StRun);
   assign result_valid = (state_q == StDone);
   assign result       = acc_q;
   assign overflow     = ovf_q;
   assign cycle_count  = cnt_q;

endmodule

// File: doc/mac_tree_engine.md
MAC_TREE_ENGINE -- requirements
Module: mac_tree_engine

Interface
REQ-001 Parameter LANES, default 8, number of parallel multiply lanes; power of two, 2..64.
REQ-002 Parameter DATA_W, default 8, operand width per lane.
REQ-003 Parameter ACC_W, default 2*DATA_W+$clog2(LANES)+8, accumulator/result width.
REQ-004 Parameter LEN_W, default 12, width of beat-count field.
REQ-005 Parameter CNT_W, default 16, width of cycle counter.
REQ-006 Port: clock  in  1  sole clock, all state on rising edge.
REQ-007 Port: reset_l  in  1  reset, asynchronous, active-low.
REQ-008 Port: start  in  1  request new dot product, sampled in IDLE only.
REQ-009 Port: length  in  LEN_W  number of input beats, latched with start.
REQ-010 Port: signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched with start.
REQ-011 Port: in_valid  in  1  a_data/b_data hold a valid beat.
REQ-012 Port: in_ready  out  1  engine accepts a beat this cycle.
REQ-013 Port: a_data  in  LANES*DATA_W  lane i operand A at bits [i*DATA_W +: DATA_W].
REQ-014 Port: b_data  in  LANES*DATA_W  lane i operand B, same packing.
REQ-015 Port: result  out  ACC_W  accumulated dot product.
REQ-016 Port: result_valid  out  1  result and cycle_count final.
REQ-017 Port: result_ready  in  1  consumer takes result.
REQ-018 Port: overflow  out  1  sticky accumulator overflow flag for current job.
REQ-019 Port: cycle_count  out  CNT_W  clock cycles spent in RUN and DRAIN for current job.

Function
REQ-020 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-021 IDLE: start=1 and length>0 -> RUN; start=1 and length=0 -> DONE; both clear accumulator, overflow, cycle_count and latch length/signed_mode.
REQ-022 in_ready = 1 only in RUN; a beat is accepted on an edge where in_valid && in_ready.
REQ-023 RUN -> DRAIN on the edge accepting beat number length; beat counter counts accepted beats only.
REQ-024 Pipeline: lane products registered on the acceptance edge; adder-tree sum registered one edge later; accumulator updated one edge after that (beat-to-accumulator latency 2 edges after acceptance).
REQ-025 DRAIN lasts exactly 2 cycles, then -> DONE on the same edge the final beat reaches the accumulator.
REQ-026 DONE: result_valid=1; result, overflow, cycle_count held stable; -> IDLE on the edge where result_ready=1.
REQ-027 start outside IDLE is ignored; in_valid outside RUN is ignored.
REQ-028 Products are 2*DATA_W wide, signed or unsigned per latched signed_mode.
REQ-029 Adder tree is $clog2(LANES) levels at width 2*DATA_W+$clog2(LANES) and cannot overflow.
REQ-030 Tree sum is sign- or zero-extended to ACC_W; accumulator wraps modulo 2^ACC_W.
REQ-031 overflow sets on any accumulate producing unsigned carry-out (signed_mode=0) or signed overflow (signed_mode=1); clears only on job start or reset.
REQ-032 cycle_count increments every cycle in RUN or DRAIN, saturates at 2^CNT_W-1; with in_valid held high it ends at length+2.
REQ-033 result equals accumulator register directly; it is meaningful only while result_valid=1.

Reset
REQ-034 On reset_l=0, immediately: state IDLE; result, overflow, cycle_count, pipeline registers, beat counter all 0; in_ready=0, result_valid=0.
REQ-035 Reset mid-job abandons the job; no partial result is ever presented.

Verification (LANES=4, DATA_W=8 unless noted)
REQ-036 Reset asserted during RUN -> all outputs 0 same cycle; after release, fresh job with length=1 completes correctly.
REQ-037 length=1, unsigned, a={1,2,3,4}, b={5,6,7,8}, in_valid high -> result=70, cycle_count=3, overflow=0.
REQ-038 length=1, a all 8'hFF, b all 8'h02: signed -> result=-8 (all ones except 3'b000 low), unsigned -> result=2040; overflow=0.
REQ-039 length=0 with start -> DONE next edge, result=0, cycle_count=0; length=3 with in_valid low 2 cycles mid-stream -> cycle_count=7.
REQ-040 ACC_W=16, unsigned, length=1, all operands 8'hFF -> result=16'hF804, overflow=1; next job clears overflow.
REQ-041 DONE with result_ready low 5 cycles and start pulsed -> result/result_valid held, start ignored; result_ready=1 -> IDLE next edge.
